// File: rtl/pwm_meter_pkg.sv
// pwm_meter_pkg: shared types for the PWM waveform meter.
//   meas_state_t - measurement FSM (ARM waits for the first rising edge, RUN counts)
//   res_state_t  - result FSM (EMPTY, DIV while the duty divide runs, FULL holding a result)
//   meas_t       - one completed measurement {hi, per, sat}
// meas_t is sized by MEAS_CNT_W; pwm_meter's CNT_W defaults to it and must stay equal.
package pwm_meter_pkg;
  localparam int MEAS_CNT_W  = 16;
  localparam int MEAS_DUTY_W = 8;

  typedef enum logic {ARM, RUN} meas_state_t;

  typedef enum logic [1:0] {EMPTY, DIV, FULL} res_state_t;

  typedef struct packed {
    logic [MEAS_CNT_W-1:0] hi;
    logic [MEAS_CNT_W-1:0] per;
    logic                  sat;
  } meas_t;
endpackage

// File: rtl/pwm_meter_if.sv
// pwm_meter_if: result channel of the PWM meter.
//   out_valid/out_ready - valid/ready handshake
//   high_cnt, period_cnt - samples high / samples per period
//   duty                - floor(high*2^DUTY_W/period), all ones when high==period
//   sat                 - a counter saturated during this measurement
//   lost                - sticky, a completed measurement was dropped since the last handshake
// master = meter side, slave = consumer side.
interface pwm_meter_if #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  period_cnt;
  logic [DUTY_W-1:0] duty;
  logic              sat;
  logic              lost;

  modport master (output out_valid, high_cnt, period_cnt, duty, sat, lost,
                  input  out_ready);
  modport slave  (input  out_valid, high_cnt, period_cnt, duty, sat, lost,
                  output out_ready);
endinterface

// File: rtl/serial_udiv.sv
// serial_udiv: restoring divider producing Q_W fractional quotient bits of num/den,
// MSB first, one bit per clk. Requires num <= den (a ratio in [0,1]).
//   clk, rst (async, active low)
//   start - load num/den; bits are produced on the following Q_W edges
//   busy  - a divide is in progress
//   done  - one-cycle pulse after the last quotient bit is written
//   quo   - quotient, valid while done is high and held until the next start
module serial_udiv #(
  parameter int NUM_W = 16,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [NUM_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quo
);
  localparam int CW = $clog2(Q_W + 1);

  logic [NUM_W-1:0] rem, dreg;
  logic [NUM_W:0]   rem2, diff;
  logic [CW-1:0]    left;
  logic             ge;

  // rem never exceeds den, so 2*rem-den fits below 2^NUM_W whenever it is
  // non-negative; the top bit of diff is therefore a pure borrow flag.
  assign rem2 = {rem, 1'b0};
  assign diff = rem2 - {1'b0, dreg};
  assign ge   = ~diff[NUM_W];
  assign busy = (left != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem  <= '0;
      dreg <= '0;
      quo  <= '0;
      left <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= num;
        dreg <= den;
        quo  <= '0;
        left <= CW'(Q_W);
      end else if (busy) begin
        rem  <= ge ? diff[NUM_W-1:0] : rem2[NUM_W-1:0];
        quo  <= {quo[Q_W-2:0], ge};
        left <= left - 1'b1;
        if (left == CW'(1)) done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/pwm_meter.sv
// pwm_meter: measures high time, period and duty of a sampled digital signal.
//   clk       - emulator clock
//   rst       - async reset, active low
//   cke       - sample enable; in is only looked at on edges with cke=1
//   in        - measured signal
//   res       - result channel (pwm_meter_if.master)
// A measurement spans one rising edge to the next. The counters and edge
// detector advance only on sampled edges; the result FSM and divider run every
// clk. Results appear DUTY_W+1 edges after the completing edge.
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W  = MEAS_CNT_W,
  parameter int DUTY_W = MEAS_DUTY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cke,
  input  logic          in,
  pwm_meter_if.master   res
);
  meas_state_t       m_state, m_nxt;
  res_state_t        r_state, r_nxt;
  logic              last, rise, comp, msat;
  logic [CNT_W-1:0]  hi_cnt, per_cnt;
  meas_t             cap;
  logic              eq;
  logic [DUTY_W-1:0] duty_q, quo;
  logic              lost_q;
  logic              capture, drop, hs, fin;
  logic              div_busy, div_done;

  // last resets high so a signal already high out of reset is not an edge.
  assign rise = cke & in & ~last;
  assign comp = rise & (m_state == RUN);

  // ---- measurement FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) m_state <= ARM;
    else      m_state <= m_nxt;
  end

  always_comb begin
    m_nxt = m_state;
    if (rise && m_state == ARM) m_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last    <= 1'b1;
      hi_cnt  <= '0;
      per_cnt <= '0;
      msat    <= 1'b0;
    end else if (cke) begin
      last <= in;
      if (rise) begin
        // the rising sample itself is the first high sample of the new period
        hi_cnt  <= CNT_W'(1);
        per_cnt <= CNT_W'(1);
        msat    <= 1'b0;
      end else if (m_state == RUN) begin
        if (&per_cnt) msat <= 1'b1;
        else          per_cnt <= per_cnt + 1'b1;
        if (in) begin
          if (&hi_cnt) msat <= 1'b1;
          else         hi_cnt <= hi_cnt + 1'b1;
        end
      end
    end
  end

  // ---- result FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= r_nxt;
  end

  always_comb begin
    r_nxt   = r_state;
    capture = 1'b0;
    drop    = 1'b0;
    hs      = 1'b0;
    fin     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (comp) begin
          capture = 1'b1;
          r_nxt   = DIV;
        end
      end
      DIV: begin
        if (comp) drop = 1'b1;
        // done pulses on the first cycle busy is low again
        if (div_done && !div_busy) begin
          fin   = 1'b1;
          r_nxt = FULL;
        end
      end
      FULL: begin
        if (res.out_ready) begin
          hs = 1'b1;
          // a completion on the handshake edge refills the slot directly
          if (comp) begin
            capture = 1'b1;
            r_nxt   = DIV;
          end else begin
            r_nxt = EMPTY;
          end
        end else if (comp) begin
          drop = 1'b1;
        end
      end
      default: r_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap    <= '0;
      eq     <= 1'b0;
      duty_q <= '0;
      lost_q <= 1'b0;
    end else begin
      if (capture) begin
        cap <= '{hi: hi_cnt, per: per_cnt, sat: msat};
        eq  <= (hi_cnt == per_cnt);
      end
      // hi==per would need a quotient of 2^DUTY_W; clamp to all ones
      if (fin) duty_q <= eq ? '1 : quo;
      if (hs)        lost_q <= 1'b0;
      else if (drop) lost_q <= 1'b1;
    end
  end

  serial_udiv #(.NUM_W(CNT_W), .Q_W(DUTY_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (capture),
    .num   (hi_cnt),
    .den   (per_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (quo)
  );

  assign res.out_valid  = (r_state == FULL);
  assign res.high_cnt   = cap.hi;
  assign res.period_cnt = cap.per;
  assign res.duty       = duty_q;
  assign res.sat        = cap.sat;
  assign res.lost       = lost_q;
endmodule
